// File: rtl/pipe_stall_ctrl.sv
// Central stall sequencer: load-use detection, divider hold, external stall merge,
// and a saturating stall-cycle counter driving the 6-bit StallBus [0]PC..[5]WB.
module pipe_stall_ctrl #(
  parameter int unsigned DIV_CYCLES = 33,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_is_load,
  input  logic             ex_rf_we,
  input  logic [4:0]       ex_rf_waddr,
  input  logic             ex_div_start,
  input  logic             ex_div_done,
  input  logic             stallreq_ext,
  output logic [5:0]       stall,
  output logic             div_busy,
  output logic             div_timeout_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned DCNT_W = $clog2(DIV_CYCLES + 1);
  localparam logic [5:0]  STALL_DIV = 6'b001111;
  localparam logic [5:0]  STALL_ID  = 6'b000111;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_DIV_BUSY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [DCNT_W-1:0]  cnt_q, cnt_d;
  logic               div_busy_q, div_busy_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               load_use;

  // Load in EX writes a register that the ID instruction reads
  always_comb begin
    load_use = ex_is_load && ex_rf_we && (ex_rf_waddr != 5'd0) &&
               ((id_use_rs && (id_rs == ex_rf_waddr)) ||
                (id_use_rt && (id_rt == ex_rf_waddr)));
  end

  // StallBus, zero-latency from state and inputs; forced quiet while in reset
  always_comb begin
    stall = 6'b000000;
    if (!resetn || flush) begin
      stall = 6'b000000;
    end else if ((state_q == S_DIV_BUSY) && !ex_div_done) begin
      stall = STALL_DIV;
    end else if ((state_q == S_IDLE) && ex_div_start) begin
      stall = STALL_DIV;
    end else if (load_use || stallreq_ext) begin
      stall = STALL_ID;
    end
  end

  // Next-state: divider FSM, timeout flag and saturating stall counter
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;

    if ((stall != 6'b000000) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (ex_div_start && !flush) begin
          state_d = S_DIV_BUSY;
          cnt_d   = DCNT_W'(DIV_CYCLES - 1);
        end
      end
      S_DIV_BUSY: begin
        if (flush || ex_div_done) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q - DCNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    div_busy_d = (state_d == S_DIV_BUSY);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_busy_q  <= 1'b0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_busy_q  <= div_busy_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign div_busy        = div_busy_q;
  assign div_timeout_err = timeout_q;
  assign stall_cnt       = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: cycle-by-cycle behavioural model
// plus directed scenarios with literal expectations.
module tb_pipe_stall_ctrl;

  localparam int unsigned DIV_CYCLES = 33;
  localparam int unsigned CNT_W      = 4;
  localparam int          CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             resetn;
  logic             flush;
  logic [4:0]       id_rs, id_rt, ex_rf_waddr;
  logic             id_use_rs, id_use_rt, ex_is_load, ex_rf_we;
  logic             ex_div_start, ex_div_done, stallreq_ext;
  logic [5:0]       stall;
  logic             div_busy, div_timeout_err;
  logic [CNT_W-1:0] stall_cnt;

  int n_pass  = 0;
  int n_total = 0;

  pipe_stall_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .flush           (flush),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .ex_is_load      (ex_is_load),
    .ex_rf_we        (ex_rf_we),
    .ex_rf_waddr     (ex_rf_waddr),
    .ex_div_start    (ex_div_start),
    .ex_div_done     (ex_div_done),
    .stallreq_ext    (stallreq_ext),
    .stall           (stall),
    .div_busy        (div_busy),
    .div_timeout_err (div_timeout_err),
    .stall_cnt       (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic m_busy;     // a divide is outstanding
  int   m_age;      // busy cycles already elapsed before the current one
  logic m_err;
  int   m_cnt;

  function automatic logic [5:0] exp_stall();
    logic hazard;
    hazard = 1'b0;
    if (ex_is_load && ex_rf_we && ex_rf_waddr != 5'd0) begin
      if (id_use_rs && id_rs == ex_rf_waddr) hazard = 1'b1;
      if (id_use_rt && id_rt == ex_rf_waddr) hazard = 1'b1;
    end
    if (!resetn || flush)                  return 6'b000000;
    if (m_busy && !ex_div_done)            return 6'b001111;
    if (!m_busy && ex_div_start)           return 6'b001111;
    if (hazard || stallreq_ext)            return 6'b000111;
    return 6'b000000;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy <= 1'b0;
      m_age  <= 0;
      m_err  <= 1'b0;
      m_cnt  <= 0;
    end else begin
      if (exp_stall() != 6'b000000 && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
      if (!m_busy) begin
        if (ex_div_start && !flush) begin
          m_busy <= 1'b1;
          m_age  <= 0;
        end
      end else if (flush || ex_div_done) begin
        m_busy <= 1'b0;
      end else if (m_age == DIV_CYCLES - 1) begin
        m_busy <= 1'b0;
        m_err  <= 1'b1;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    check("model_stall",     32'(stall),           32'(exp_stall()));
    check("model_div_busy",  32'(div_busy),        32'(m_busy));
    check("model_timeout",   32'(div_timeout_err), 32'(m_err));
    check("model_stall_cnt", 32'(stall_cnt),       32'(m_cnt));
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hazard();
    ex_is_load = 1'b0; ex_rf_we = 1'b0; ex_rf_waddr = 5'd0;
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int busy_cycles;
    resetn = 1'b0; flush = 1'b0; ex_div_start = 1'b0; ex_div_done = 1'b0;
    stallreq_ext = 1'b0;
    clear_hazard();
    #3;
    check("rst_stall",     32'(stall),           32'h0);
    check("rst_div_busy",  32'(div_busy),        32'h0);
    check("rst_timeout",   32'(div_timeout_err), 32'h0);
    check("rst_stall_cnt", 32'(stall_cnt),       32'h0);
    step(); step();
    resetn = 1'b1;
    step();

    // Load-use on rs: one-cycle ID stall
    ex_is_load = 1'b1; ex_rf_we = 1'b1; ex_rf_waddr = 5'd2; id_use_rs = 1'b1; id_rs = 5'd2;
    #2 check("lu_rs_stall", 32'(stall), 32'h07);
    step();
    clear_hazard();
    #2 check("lu_rs_clear", 32'(stall), 32'h00);
    check("lu_rs_cnt", 32'(stall_cnt), 32'd1);

    // r0 destination and unused source never stall; rt path does
    step();
    ex_is_load = 1'b1; ex_rf_we = 1'b1; ex_rf_waddr = 5'd0; id_use_rs = 1'b1; id_rs = 5'd0;
    #2 check("lu_r0", 32'(stall), 32'h00);
    step();
    ex_rf_waddr = 5'd5; id_rs = 5'd5; id_use_rs = 1'b0;
    #2 check("lu_rs_unused", 32'(stall), 32'h00);
    step();
    id_use_rt = 1'b1; id_rt = 5'd5;
    #2 check("lu_rt_stall", 32'(stall), 32'h07);
    step();
    clear_hazard();

    // Divide completing after 10 cycles
    step();
    ex_div_start = 1'b1;
    #2 check("div_start_stall", 32'(stall), 32'h0F);
    for (int i = 1; i <= 9; i++) begin
      step();
      ex_div_start = (i == 3);
      #2;
      if (i == 5) begin
        check("div_mid_busy",  32'(div_busy), 32'h1);
        check("div_mid_stall", 32'(stall),    32'h0F);
      end
    end
    step();
    ex_div_start = 1'b0; ex_div_done = 1'b1;
    #2 check("div_done_stall", 32'(stall),    32'h00);
    check("div_done_busy",     32'(div_busy), 32'h1);
    step();
    ex_div_done = 1'b0;
    #2 check("div_after_busy", 32'(div_busy), 32'h0);

    // Divide with no done: timeout after DIV_CYCLES busy cycles
    step();
    ex_div_start = 1'b1;
    step();
    ex_div_start = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 100 && div_busy; i++) begin
      busy_cycles++;
      step();
    end
    check("timeout_busy_cycles", 32'(busy_cycles), 32'(DIV_CYCLES));
    check("timeout_err_set",     32'(div_timeout_err), 32'h1);
    step(); step();
    check("timeout_err_sticky",  32'(div_timeout_err), 32'h1);

    // Flush on the 5th busy cycle together with done
    ex_div_start = 1'b1;
    step();
    ex_div_start = 1'b0;
    step(); step(); step(); step();
    flush = 1'b1; ex_div_done = 1'b1;
    #2 check("flush_stall", 32'(stall), 32'h00);
    step();
    flush = 1'b0; ex_div_done = 1'b0;
    #2 check("flush_idle_busy", 32'(div_busy), 32'h0);

    // Asynchronous reset in the middle of a divide
    step();
    ex_div_start = 1'b1;
    step();
    ex_div_start = 1'b0;
    step(); step();
    #1 resetn = 1'b0;
    #1;
    check("arst_stall",     32'(stall),           32'h0);
    check("arst_div_busy",  32'(div_busy),        32'h0);
    check("arst_timeout",   32'(div_timeout_err), 32'h0);
    check("arst_stall_cnt", 32'(stall_cnt),       32'h0);
    step(); step();
    resetn = 1'b1;
    step();

    // Saturation: 2^CNT_W + 5 external stall cycles
    stallreq_ext = 1'b1;
    for (int i = 0; i < (1 << CNT_W) + 5; i++) step();
    stallreq_ext = 1'b0;
    #2 check("sat_stall_cnt", 32'(stall_cnt), 32'(CNT_MAX));
    check("sat_stall_idle", 32'(stall), 32'h00);

    step(); step();
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
